// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I datapath.
// Walks each instruction through fetch, decode, execute, memory and
// writeback, and drives the datapath mux selects, enables and the 2-bit
// alu_op that the downstream ALU-control decoder expands.
//
// Memory handshake: the FSM presents a request (the fetch in FETCH, the
// read in MEMREAD, or mem_write in MEMWRITE) and holds it steady until
// mem_ready is 1. A request and mem_ready both high in the same cycle is
// one completed transfer, and the FSM leaves the state on that edge, so
// each access is accepted exactly once.
module multicycle_control #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               adr_src,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_write,
   output logic [1:0]         result_src,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         imm_src,
   output logic               illegal_instr,
   output logic [STATE_W-1:0] state_dbg
);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = STATE_W'(0),
      S_DECODE   = STATE_W'(1),
      S_MEMADR   = STATE_W'(2),
      S_MEMREAD  = STATE_W'(3),
      S_MEMWB    = STATE_W'(4),
      S_MEMWRITE = STATE_W'(5),
      S_EXECUTER = STATE_W'(6),
      S_EXECUTEI = STATE_W'(7),
      S_ALUWB    = STATE_W'(8),
      S_BEQ      = STATE_W'(9),
      S_JAL      = STATE_W'(10)
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   state_t state;
   state_t state_next;

   assign state_dbg = state;

   // State register; reset wins over any in-flight instruction or handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and Moore output decode; everything defaults to 0.
   always_comb begin
      state_next    = S_FETCH;
      pc_write      = 1'b0;
      adr_src       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      imm_src       = 2'b00;
      illegal_instr = 1'b0;

      case (state)
         S_FETCH: begin
            // PC + 4 computed by the ALU goes straight back into the PC.
            adr_src    = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b10;
            alu_op     = 2'b01;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            state_next = mem_ready ? S_DECODE : S_FETCH;
         end

         S_DECODE: begin
            // Speculatively compute old PC + imm as the branch/jump target.
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            alu_op    = 2'b01;
            case (opcode)
               OP_LOAD: begin
                  imm_src    = 2'b00;
                  state_next = S_MEMADR;
               end
               OP_STORE: begin
                  imm_src    = 2'b01;
                  state_next = S_MEMADR;
               end
               OP_RTYPE: begin
                  imm_src    = 2'b00;
                  state_next = S_EXECUTER;
               end
               OP_ITYPE: begin
                  imm_src    = 2'b00;
                  state_next = S_EXECUTEI;
               end
               OP_BRANCH: begin
                  imm_src    = 2'b10;
                  state_next = S_BEQ;
               end
               OP_JAL: begin
                  imm_src    = 2'b11;
                  state_next = S_JAL;
               end
               default: begin
                  illegal_instr = 1'b1;
                  state_next    = S_FETCH;
               end
            endcase
         end

         S_MEMADR: begin
            // opcode[5] separates store (1) from load (0).
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            alu_op     = 2'b01;
            imm_src    = opcode[5] ? 2'b01 : 2'b00;
            state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         end

         S_MEMREAD: begin
            adr_src    = 1'b1;
            result_src = 2'b00;
            state_next = mem_ready ? S_MEMWB : S_MEMREAD;
         end

         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_next = S_FETCH;
         end

         S_MEMWRITE: begin
            // Request held until accepted; leaving on acceptance gives one write.
            adr_src    = 1'b1;
            result_src = 2'b00;
            mem_write  = 1'b1;
            state_next = mem_ready ? S_FETCH : S_MEMWRITE;
         end

         S_EXECUTER: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            state_next = S_ALUWB;
         end

         S_EXECUTEI: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            alu_op     = 2'b10;
            imm_src    = 2'b00;
            state_next = S_ALUWB;
         end

         S_ALUWB: begin
            result_src = 2'b00;
            reg_write  = 1'b1;
            state_next = S_FETCH;
         end

         S_BEQ: begin
            // rs1 - rs2; the target from DECODE sits in the ALU-out register.
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b00;
            alu_op     = 2'b11;
            result_src = 2'b00;
            imm_src    = 2'b10;
            pc_write   = zero;
            state_next = S_FETCH;
         end

         S_JAL: begin
            // PC <- target from DECODE while the ALU forms old PC + 4 for rd.
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            alu_op     = 2'b01;
            result_src = 2'b00;
            pc_write   = 1'b1;
            imm_src    = 2'b11;
            state_next = S_ALUWB;
         end

         default: begin
            state_next = S_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control.
module tb_multicycle_control;

   logic       clk;
   logic       rst_n;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] imm_src;
   logic       illegal_instr;
   logic [3:0] state_dbg;

   multicycle_control #(.STATE_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .adr_src       (adr_src),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .reg_write     (reg_write),
      .result_src    (result_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .imm_src       (imm_src),
      .illegal_instr (illegal_instr),
      .state_dbg     (state_dbg)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MB = 4'd4,
                          MW = 4'd5, ER = 4'd6, EI = 4'd7, AW = 4'd8, BQ = 4'd9,
                          JL = 4'd10;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                          IT = 7'b0010011, BE = 7'b1100011, JA = 7'b1101111,
                          IL = 7'b0000000;

   typedef struct {
      logic [6:0]  op;
      logic        z;
      logic        rdy;
      logic [3:0]  st;
      logic [15:0] o;
   } vec_t;

   vec_t        tbl[$];
   logic [19:0] exp_q[$];

   int n_cmp;
   int n_bad;
   int illegal_cnt;
   int overlap_cnt;

   // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
   //  alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr}
   function automatic logic [15:0] e(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, a, b, op, imm,
                                     input logic ill);
      return {pcw, adr, mw, irw, rw, rs, a, b, op, imm, ill};
   endfunction

   function automatic logic [15:0] outs();
      return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
              alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr};
   endfunction

   task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got state=%0d outs=%h, wanted state=%0d outs=%h",
                  name, act[19:16], act[15:0], exp[19:16], exp[15:0]);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, sample 1 ns later.
   task automatic drive(input logic rn, input logic [6:0] op, input logic z, input logic rdy);
      @(negedge clk);
      rst_n     = rn;
      opcode    = op;
      zero      = z;
      mem_ready = rdy;
      #1;
      if (illegal_instr) illegal_cnt++;
      if (reg_write && mem_write) overlap_cnt++;
   endtask

   task automatic add(input logic [6:0] op, input logic z, input logic rdy,
                      input logic [3:0] st, input logic [15:0] o);
      tbl.push_back('{op: op, z: z, rdy: rdy, st: st, o: o});
   endtask

   logic [15:0] f1, f0, mr, mb, mw, er, ei, aw, jl;

   initial begin
      n_cmp = 0; n_bad = 0; illegal_cnt = 0; overlap_cnt = 0;
      rst_n = 1'b0; opcode = IL; zero = 1'b0; mem_ready = 1'b0;

      f1 = e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,2'b00,0);
      f0 = e(0,0,0,0,0,2'b10,2'b00,2'b10,2'b01,2'b00,0);
      mr = e(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0);
      mb = e(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,2'b00,0);
      mw = e(0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0);
      er = e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,2'b00,0);
      ei = e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,2'b00,0);
      aw = e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0);
      jl = e(1,0,0,0,0,2'b00,2'b01,2'b10,2'b01,2'b11,0);

      // Stalled fetch, then lw with ready throughout.
      add(LW,0,0,F,f0);
      add(LW,0,1,F,f1);
      add(LW,0,1,D,e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,2'b00,0));
      add(LW,0,1,MA,e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,2'b00,0));
      add(LW,0,1,MR,mr);
      add(LW,0,1,MB,mb);
      // sw, write stalled three cycles: 7 cycles total.
      add(SW,0,1,F,f1);
      add(SW,0,1,D,e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,2'b01,0));
      add(SW,0,1,MA,e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,2'b01,0));
      add(SW,0,0,MW,mw);
      add(SW,0,0,MW,mw);
      add(SW,0,0,MW,mw);
      add(SW,0,1,MW,mw);
      // lw with one read stall.
      add(LW,0,1,F,f1);
      add(LW,0,1,D,e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,2'b00,0));
      add(LW,0,1,MA,e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,2'b00,0));
      add(LW,0,0,MR,mr);
      add(LW,0,1,MR,mr);
      add(LW,0,1,MB,mb);
      // R-type, then I-type.
      add(RT,0,1,F,f1);
      add(RT,0,1,D,e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,2'b00,0));
      add(RT,0,1,ER,er);
      add(RT,0,1,AW,aw);
      add(IT,0,1,F,f1);
      add(IT,0,1,D,e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,2'b00,0));
      add(IT,0,1,EI,ei);
      add(IT,0,1,AW,aw);
      // beq taken, then not taken.
      add(BE,1,1,F,f1);
      add(BE,1,1,D,e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,2'b10,0));
      add(BE,1,1,BQ,e(1,0,0,0,0,2'b00,2'b10,2'b00,2'b11,2'b10,0));
      add(BE,0,1,F,f1);
      add(BE,0,1,D,e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,2'b10,0));
      add(BE,0,1,BQ,e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b11,2'b10,0));
      // jal, then an illegal opcode.
      add(JA,0,1,F,f1);
      add(JA,0,1,D,e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,2'b11,0));
      add(JA,0,1,JL,jl);
      add(JA,0,1,AW,aw);
      add(IL,0,1,F,f1);
      add(IL,0,1,D,e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,2'b00,1));
      add(IL,0,1,F,f1);

      foreach (tbl[i]) exp_q.push_back({tbl[i].st, tbl[i].o});

      // Reset: two cycles low.
      drive(1'b0, IL, 1'b0, 1'b0);
      drive(1'b0, IL, 1'b0, 1'b0);
      check("reset_state", {state_dbg, outs()}, {F, f0});

      for (int i = 0; i < tbl.size(); i++) begin
         logic [19:0] exp_w;
         drive(1'b1, tbl[i].op, tbl[i].z, tbl[i].rdy);
         exp_w = exp_q.pop_front();
         check($sformatf("vec%0d", i), {state_dbg, outs()}, exp_w);
      end

      // Reset mid-MEMWRITE with mem_write active.
      drive(1'b1, SW, 1'b0, 1'b1);  // DECODE
      drive(1'b1, SW, 1'b0, 1'b1);  // MEMADR
      drive(1'b1, SW, 1'b0, 1'b0);  // MEMWRITE
      check("rst_pre_memwrite", {state_dbg, outs()}, {MW, mw});
      drive(1'b0, SW, 1'b0, 1'b0);  // rst_n sampled low at the next edge
      check("rst_low_still_memwrite", {state_dbg, outs()}, {MW, mw});
      drive(1'b0, SW, 1'b0, 1'b0);
      check("rst_fetch_no_write", {state_dbg, outs()}, {F, f0});
      drive(1'b1, LW, 1'b0, 1'b0);
      check("post_rst_fetch_stall", {state_dbg, outs()}, {F, f0});
      drive(1'b1, LW, 1'b0, 1'b1);
      check("post_rst_first_irwrite", {state_dbg, outs()}, {F, f1});
      drive(1'b1, LW, 1'b0, 1'b1);
      check("post_rst_decode", {state_dbg, outs()},
            {D, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,2'b00,0)});

      n_cmp++;
      if (illegal_cnt != 1) begin
         n_bad++;
         $display("FAIL illegal_pulses: got %0d, wanted 1", illegal_cnt);
      end
      n_cmp++;
      if (overlap_cnt != 0) begin
         n_bad++;
         $display("FAIL write_overlap: got %0d, wanted 0", overlap_cnt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
